// File: rtl/game_pkg.sv
// Shared definitions for the rhythm-game score controller.
//   - FSM state encoding (also the value driven on the 2-bit state output)
//   - Combo multiplier limits: mult = 1 + min(combo >> COMBO_SHIFT, MULT_MAX-1)
package game_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PLAYING = 2'b01;
    localparam logic [1:0] ST_OVER    = 2'b10;

    localparam int MULT_MAX    = 4;
    localparam int COMBO_SHIFT = 4;

endpackage

// File: rtl/lane_popcount.sv
// Combinational count of set bits across the lane vector.
// Ports:
//   bits   in   N_LANES              one bit per lane
//   count  out  $clog2(N_LANES+1)    number of bits set
module lane_popcount #(
    parameter int N_LANES = 8,
    localparam int CNT_W  = $clog2(N_LANES + 1)
) (
    input  logic [N_LANES-1:0] bits,
    output logic [CNT_W-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_LANES; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/game_score_ctrl.sv
// Game/score controller for the N-lane rhythm game.
// Runs the IDLE/PLAYING/GAME_OVER FSM, accumulates a saturating score from
// per-lane hit pulses, tracks the session best score and drives a registered
// display word (score or max_score).
// Optional feature macro: GAME_COMBO_EN (combo counter and score multiplier).
// Ports:
//   CLOCK_25     in   1        system clock
//   rst_n        in   1        asynchronous active-low reset
//   hit          in   N_LANES  per-lane hit pulse
//   miss         in   N_LANES  per-lane miss pulse (combo reset only)
//   start_btn    in   1        start request level, rising edge starts a game
//   end_of_list  in   1        pattern list exhausted, ends the game
//   show_max     in   1        display select: 1 max_score, 0 score
//   state        out  2        00 IDLE, 01 PLAYING, 10 GAME_OVER
//   score        out  SCORE_W  current score
//   max_score    out  SCORE_W  best score since reset
//   display      out  SCORE_W  registered score/max_score mux
//   combo        out  COMBO_W  current combo (0 without GAME_COMBO_EN)
module game_score_ctrl
    import game_pkg::*;
#(
    parameter int N_LANES = 8,
    parameter int SCORE_W = 20,
    parameter int COMBO_W = 8
) (
    input  logic               CLOCK_25,
    input  logic               rst_n,
    input  logic [N_LANES-1:0] hit,
    input  logic [N_LANES-1:0] miss,
    input  logic               start_btn,
    input  logic               end_of_list,
    input  logic               show_max,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] max_score,
    output logic [SCORE_W-1:0] display,
    output logic [COMBO_W-1:0] combo
);

    localparam int CNT_W = $clog2(N_LANES + 1);
    localparam int PTS_W = CNT_W + 3;           // room for hit count * MULT_MAX
    localparam int SUM_W = SCORE_W + PTS_W;     // score + pts never overflows
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    logic [1:0]         state_reg, state_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [SCORE_W-1:0] max_reg, max_next;
    logic [SCORE_W-1:0] display_reg;
    logic               start_q_reg;
    logic               start_rise;
    logic               playing;
    logic               restart;

    logic [CNT_W-1:0]   hit_cnt;
    logic [2:0]         mult;
    logic [PTS_W-1:0]   pts;
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] sat_score;

    lane_popcount #(.N_LANES(N_LANES)) u_hit_count (
        .bits  (hit),
        .count (hit_cnt)
    );

    assign start_rise = start_btn & ~start_q_reg;
    assign playing    = (state_reg == ST_PLAYING);
    // A start edge only matters outside PLAYING; it also clears score/combo.
    assign restart    = start_rise & ((state_reg == ST_IDLE) | (state_reg == ST_OVER));

`ifdef GAME_COMBO_EN
    logic [COMBO_W-1:0] combo_reg, combo_next;
    logic [COMBO_W-1:0] combo_tier;
    logic [COMBO_W:0]   combo_sum;

    // Multiplier uses the combo value before this cycle's update.
    assign combo_tier = combo_reg >> COMBO_SHIFT;
    assign mult = (combo_tier >= COMBO_W'(MULT_MAX - 1)) ? 3'(MULT_MAX)
                                                         : 3'(combo_tier) + 3'd1;
    assign combo_sum = {1'b0, combo_reg} + (COMBO_W + 1)'(hit_cnt);

    always_comb begin
        combo_next = combo_reg;
        if (restart) begin
            combo_next = '0;
        end else if (playing) begin
            if (|miss) begin
                combo_next = '0;                       // a miss beats any hit
            end else if (combo_sum[COMBO_W]) begin
                combo_next = {COMBO_W{1'b1}};
            end else begin
                combo_next = combo_sum[COMBO_W-1:0];
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge rst_n) begin
        if (!rst_n) begin
            combo_reg <= '0;
        end else begin
            combo_reg <= combo_next;
        end
    end

    assign combo = combo_reg;
`else
    logic unused_miss;

    assign unused_miss = ^miss;
    assign mult        = 3'd1;
    assign combo       = '0;
`endif

    assign pts       = PTS_W'(hit_cnt) * PTS_W'(mult);
    assign sum       = SUM_W'(score_reg) + SUM_W'(pts);
    assign sat_score = (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];

    always_comb begin
        state_next = state_reg;
        score_next = score_reg;
        max_next   = max_reg;
        case (state_reg)
            ST_IDLE, ST_OVER: begin
                if (restart) begin
                    state_next = ST_PLAYING;
                    score_next = '0;
                end
            end
            ST_PLAYING: begin
                // Hits in the end_of_list cycle still count.
                score_next = sat_score;
                if (sat_score > max_reg) begin
                    max_next = sat_score;
                end
                if (end_of_list) begin
                    state_next = ST_OVER;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_25 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            score_reg   <= '0;
            max_reg     <= '0;
            display_reg <= '0;
            start_q_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            score_reg   <= score_next;
            max_reg     <= max_next;
            display_reg <= show_max ? max_reg : score_reg;
            start_q_reg <= start_btn;
        end
    end

    assign state     = state_reg;
    assign score     = score_reg;
    assign max_score = max_reg;
    assign display   = display_reg;

endmodule

// File: tb/tb_game_score_ctrl.sv
module tb_game_score_ctrl;

`ifdef GAME_COMBO_EN
    localparam bit COMBO_EN = 1'b1;
`else
    localparam bit COMBO_EN = 1'b0;
`endif
    localparam int SMAX = (1 << 20) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  hit, miss;
    logic        start_btn, end_of_list, show_max;
    logic [1:0]  state;
    logic [19:0] score, max_score, display;
    logic [7:0]  combo;

    // Narrow-score instance for saturation
    logic [7:0]  t_hit;
    logic        t_start;
    logic [1:0]  t_state;
    logic [3:0]  t_score, t_max, t_disp;
    logic [7:0]  t_combo;

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    game_score_ctrl #(.N_LANES(8), .SCORE_W(20), .COMBO_W(8)) dut (
        .CLOCK_25(clk), .rst_n(rst_n), .hit(hit), .miss(miss),
        .start_btn(start_btn), .end_of_list(end_of_list), .show_max(show_max),
        .state(state), .score(score), .max_score(max_score),
        .display(display), .combo(combo)
    );

    game_score_ctrl #(.N_LANES(8), .SCORE_W(4), .COMBO_W(8)) dut_small (
        .CLOCK_25(clk), .rst_n(rst_n), .hit(t_hit), .miss(8'h00),
        .start_btn(t_start), .end_of_list(1'b0), .show_max(1'b1),
        .state(t_state), .score(t_score), .max_score(t_max),
        .display(t_disp), .combo(t_combo)
    );

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic [19:0] sc;
        logic [19:0] mx;
        logic [19:0] dp;
        logic [7:0]  cb;
    } exp_t;

    exp_t q[$];
    int   sq[$];

    // Reference model state
    int   m_st, m_sc, m_mx, m_cb;
    logic m_sq;

    task automatic model_reset();
        m_st = 0; m_sc = 0; m_mx = 0; m_cb = 0; m_sq = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        checks++; assert (state === 2'b00) else begin errors++; $error("FAIL %s state got %0d want 0", tag, state); end
        checks++; assert (score === 20'd0) else begin errors++; $error("FAIL %s score got %0d want 0", tag, score); end
        checks++; assert (max_score === 20'd0) else begin errors++; $error("FAIL %s max got %0d want 0", tag, max_score); end
        checks++; assert (display === 20'd0) else begin errors++; $error("FAIL %s display got %0d want 0", tag, display); end
        checks++; assert (combo === 8'd0) else begin errors++; $error("FAIL %s combo got %0d want 0", tag, combo); end
    endtask

    task automatic step(input logic [7:0] h, input logic [7:0] m, input logic e,
                        input logic s, input logic sm, input string tag);
        exp_t x, y;
        int   pc, mult, tier;
        logic rise;
        hit = h; miss = m; end_of_list = e; start_btn = s; show_max = sm;
        x.tag = tag;
        x.dp  = sm ? 20'(m_mx) : 20'(m_sc);
        rise  = s && !m_sq;
        m_sq  = s;
        if (m_st != 1) begin
            if (rise) begin
                m_st = 1; m_sc = 0; m_cb = 0;
            end
        end else begin
            pc   = $countones(h);
            tier = m_cb / 16;
            mult = COMBO_EN ? 1 + ((tier > 3) ? 3 : tier) : 1;
            m_sc = m_sc + pc * mult;
            if (m_sc > SMAX) m_sc = SMAX;
            if (COMBO_EN) begin
                if (m != 8'h00) m_cb = 0;
                else m_cb = (m_cb + pc > 255) ? 255 : m_cb + pc;
            end
            if (m_sc > m_mx) m_mx = m_sc;
            if (e) m_st = 2;
        end
        x.st = 2'(m_st); x.sc = 20'(m_sc); x.mx = 20'(m_mx); x.cb = 8'(m_cb);
        q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        hit = 8'h00; miss = 8'h00; end_of_list = 1'b0;
        y = q.pop_front();
        checks++; assert (state === y.st) else begin errors++; $error("FAIL %s state got %0d want %0d", y.tag, state, y.st); end
        checks++; assert (score === y.sc) else begin errors++; $error("FAIL %s score got %0d want %0d", y.tag, score, y.sc); end
        checks++; assert (max_score === y.mx) else begin errors++; $error("FAIL %s max got %0d want %0d", y.tag, max_score, y.mx); end
        checks++; assert (display === y.dp) else begin errors++; $error("FAIL %s display got %0d want %0d", y.tag, display, y.dp); end
        checks++; assert (combo === y.cb) else begin errors++; $error("FAIL %s combo got %0d want %0d", y.tag, combo, y.cb); end
        $display("step %-16s hit=%h miss=%h eol=%0b start=%0b show=%0b -> state=%0d score=%0d max=%0d disp=%0d combo=%0d",
                 y.tag, h, m, e, s, sm, state, score, max_score, display, combo);
    endtask

    initial begin
        int exp_s;
        rst_n = 1'b0;
        hit = 8'h00; miss = 8'h00; start_btn = 1'b0; end_of_list = 1'b0; show_max = 1'b0;
        t_hit = 8'h00; t_start = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Game 1: start edge, hold, single hits, all-lane hit
        step(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, "idle_hit_ign");
        step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "start_rise");
        step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "start_hold");
        for (int i = 0; i < 5; i++) step(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, "hit_single");
        step(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, "hit_all");
        step(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, "show_max_play");

        // Asynchronous reset mid-game
        #5;
        rst_n = 1'b0;
        start_btn = 1'b0;
        #1;
        check_zero("reset_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Game 2: end_of_list with a simultaneous hit, restart
        step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "start2");
        for (int i = 0; i < 7; i++) step(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, "hit_to7");
        step(8'h03, 8'h00, 1'b1, 1'b1, 1'b0, "eol_with_hit");
        step(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, "over_hit_ign");
        step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "start_low");
        step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "restart");
        step(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, "hit_after_rst");
        step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "start_low2");
        step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "start_in_play");
        step(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "eol_only");
        step(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, "show_max_1");
        step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "show_max_0");
        step(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, "show_max_1b");

        // Game 3: long run of single hits, then a miss with a hit
        step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "start_low3");
        step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "start3");
        for (int i = 0; i < 16; i++) step(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, "combo_build");
        step(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, "combo_mult");
        step(8'h01, 8'h04, 1'b0, 1'b1, 1'b0, "miss_with_hit");
        step(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, "after_miss");
        step(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "eol3");

        // Narrow score: saturation at 15
        t_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; assert (t_state === 2'b01) else begin errors++; $error("FAIL sat_start state got %0d want 1", t_state); end
        for (int i = 1; i <= 20; i++) begin
            sq.push_back((i > 15) ? 15 : i);
            t_hit = 8'h01;
            @(posedge clk);
            @(negedge clk);
            t_hit = 8'h00;
            exp_s = sq.pop_front();
            checks++; assert (t_score === 4'(exp_s)) else begin errors++; $error("FAIL sat_hit%0d score got %0d want %0d", i, t_score, exp_s); end
            $display("sat   hit %0d -> score=%0d max=%0d", i, t_score, t_max);
        end
        checks++; assert (t_max === 4'd15) else begin errors++; $error("FAIL sat_max got %0d want 15", t_max); end
        @(negedge clk);
        checks++; assert (t_disp === 4'd15) else begin errors++; $error("FAIL sat_disp got %0d want 15", t_disp); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
